// File: rtl/game_pkg.sv
// Shared constants for the game controller's score/display path: display modes,
// conversion FSM encoding and active-low seven-segment patterns.
package game_pkg;

    localparam int SCORE_W    = 13;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [1:0] DISP_BLANK = 2'b00;
    localparam logic [1:0] DISP_SCORE = 2'b01;
    localparam logic [1:0] DISP_FULL  = 2'b10;
    localparam logic [1:0] DISP_DASH  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } convState_t;

    // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] digitToSeg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
    function automatic logic [BCD_W-1:0] addThree(input logic [BCD_W-1:0] scratch);
        logic [BCD_W-1:0] adjusted;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adjusted[i*4 +: 4] = (scratch[i*4 +: 4] >= 4'd5) ? scratch[i*4 +: 4] + 4'd3
                                                             : scratch[i*4 +: 4];
        end
        return adjusted;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-and-add-3 binary to BCD converter with a one-deep pending slot;
// the committed BCD register only ever holds complete results.
module bin2bcd_serial
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] value,
    output logic               busy,
    output logic [BCD_W-1:0]   bcd
);

    convState_t         state;
    convState_t         stateNext;
    logic [SCORE_W-1:0] loadValue;
    logic [SCORE_W-1:0] shiftReg;
    logic [SCORE_W-1:0] pendingValue;
    logic               pendingValid;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   scratchNext;
    logic [3:0]         shiftCnt;
    logic               lastShift;

    assign adjusted    = addThree(scratch);
    assign scratchNext = (adjusted << 1) | {{(BCD_W-1){1'b0}}, shiftReg[SCORE_W-1]};
    assign lastShift   = (state == SHIFT) && (shiftCnt == 4'(SCORE_W - 1));
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: stateNext gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = LOAD;
            LOAD:    stateNext = SHIFT;
            SHIFT:   if (lastShift) stateNext = (start || pendingValid) ? LOAD : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: non-blocking throughout so the shift and the commit both see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loadValue    <= '0;
            shiftReg     <= '0;
            pendingValue <= '0;
            pendingValid <= 1'b0;
            scratch      <= '0;
            shiftCnt     <= '0;
            bcd          <= '0;
        end else begin
            case (state)
                IDLE: if (start) loadValue <= value;
                LOAD: begin
                    scratch  <= '0;
                    shiftReg <= loadValue;
                    shiftCnt <= '0;
                end
                SHIFT: begin
                    scratch  <= scratchNext;
                    shiftReg <= shiftReg << 1;
                    shiftCnt <= shiftCnt + 4'd1;
                end
                default: ;
            endcase

            // A strobe on the completion edge is newer than any held pending value.
            if (lastShift) begin
                bcd          <= scratchNext;
                pendingValid <= 1'b0;
                if (start) begin
                    loadValue <= value;
                end else if (pendingValid) begin
                    loadValue <= pendingValue;
                end
            end else if (start && busy) begin
                pendingValid <= 1'b1;
                pendingValue <= value;
            end
        end
    end

endmodule

// File: rtl/score_display_driver.sv
// Drives a 4-digit multiplexed seven-segment display from the controller's score,
// with a free-running refresh scan and registered anode/segment outputs.
module score_display_driver
    import game_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] display_score,
    input  logic [1:0]         display_ctrl,
    input  logic               score_valid,
    output logic               busy,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [BCD_W-1:0]      bcd;
    logic [CNT_W-1:0]      refreshCnt;
    logic [1:0]            digitIdx;
    logic [1:0]            msdIdx;
    logic [3:0]            curDigit;
    logic [NUM_DIGITS-1:0] digitSel;
    logic [NUM_DIGITS-1:0] anNext;
    logic [6:0]            segNext;

    bin2bcd_serial converter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (score_valid),
        .value (display_score),
        .busy  (busy),
        .bcd   (bcd)
    );

    assign dp = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refreshCnt <= '0;
            digitIdx   <= '0;
        end else if (refreshCnt == CNT_W'(REFRESH_DIV - 1)) begin
            refreshCnt <= '0;
            digitIdx   <= digitIdx + 2'd1;
        end else begin
            refreshCnt <= refreshCnt + 1'b1;
        end
    end

    assign curDigit = bcd[{digitIdx, 2'b00} +: 4];
    assign digitSel = ~(NUM_DIGITS'(1) << digitIdx);

    // Highest non-zero digit; stays 0 for a zero score so digit 0 is always lit.
    always_comb begin
        msdIdx = 2'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) msdIdx = 2'(i);
        end
    end

    always_comb begin
        anNext  = '1;
        segNext = SEG_BLANK;
        case (display_ctrl)
            DISP_BLANK: ;
            DISP_SCORE: begin
                if (digitIdx <= msdIdx) begin
                    anNext  = digitSel;
                    segNext = digitToSeg(curDigit);
                end
            end
            DISP_FULL: begin
                anNext  = digitSel;
                segNext = digitToSeg(curDigit);
            end
            DISP_DASH: begin
                anNext  = digitSel;
                segNext = SEG_DASH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= anNext;
            seg <= segNext;
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver: scoreboard of expected committed BCD values
// plus display scans decoded against an independent segment table.
module tb_score_display_driver;

    localparam int REFRESH_DIV = 4;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] OFF  = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] display_score = '0;
    logic [1:0]  display_ctrl = 2'b01;
    logic        score_valid = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          passCnt = 0;
    int          totalCnt = 0;
    logic [15:0] expQ [$];
    logic [3:0]  scanLit;
    logic [6:0]  scanSeg [4];
    logic        scanBad;

    score_display_driver #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .display_score (display_score),
        .display_ctrl  (display_ctrl),
        .score_valid   (score_valid),
        .busy          (busy),
        .an            (an),
        .seg           (seg),
        .dp            (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkCommitted(input string tag);
        logic [15:0] exp;
        exp = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
        check(tag, dut.converter.bcd, exp);
    endtask

    // Strobe one value from idle and count the cycles busy stays high.
    task automatic convert(input int value, output int busyCycles);
        display_score = 13'(value);
        score_valid   = 1'b1;
        expQ.push_back(toBcd(value));
        tick();
        score_valid = 1'b0;
        busyCycles  = 0;
        while (busy === 1'b1 && busyCycles < 200) begin
            busyCycles++;
            tick();
        end
    endtask

    // 16 cycles visits every digit index for REFRESH_DIV cycles each.
    task automatic captureScan();
        scanLit = '0;
        scanBad = 1'b0;
        for (int i = 0; i < 4; i++) scanSeg[i] = OFF;
        for (int c = 0; c < 4 * REFRESH_DIV; c++) begin
            tick();
            case (an)
                4'b1110: begin scanLit[0] = 1'b1; scanSeg[0] = seg; end
                4'b1101: begin scanLit[1] = 1'b1; scanSeg[1] = seg; end
                4'b1011: begin scanLit[2] = 1'b1; scanSeg[2] = seg; end
                4'b0111: begin scanLit[3] = 1'b1; scanSeg[3] = seg; end
                4'b1111: if (seg !== OFF) scanBad = 1'b1;
                default: scanBad = 1'b1;
            endcase
        end
    endtask

    task automatic checkScan(input string tag, input logic [3:0] expLit,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
        captureScan();
        check({tag, " lit"}, 16'(scanLit), 16'(expLit));
        check({tag, " anode"}, 16'(scanBad), 16'd0);
        if (expLit[0]) check({tag, " d0"}, 16'(scanSeg[0]), 16'(e0));
        if (expLit[1]) check({tag, " d1"}, 16'(scanSeg[1]), 16'(e1));
        if (expLit[2]) check({tag, " d2"}, 16'(scanSeg[2]), 16'(e2));
        if (expLit[3]) check({tag, " d3"}, 16'(scanSeg[3]), 16'(e3));
    endtask

    initial begin
        int  busyCycles;
        int  busyRun;
        bit  runOpen;
        bit  sawSeven;

        // Reset state, mode 01.
        tick();
        tick();
        check("reset an", 16'(an), 16'hF);
        check("reset seg", 16'(seg), 16'(OFF));
        check("reset busy", 16'(busy), 16'd0);
        check("reset dp", 16'(dp), 16'd1);
        rst_n = 1'b1;
        tick();
        check("post-reset an", 16'(an), 16'b1110);
        check("post-reset seg", 16'(seg), 16'(SEG_TABLE[0]));
        checkScan("zero blanking", 4'b0001, OFF, OFF, OFF, SEG_TABLE[0]);

        // Maximum score, all digits shown.
        display_ctrl = 2'b10;
        convert(8191, busyCycles);
        check("8191 busy cycles", 16'(busyCycles), 16'd14);
        checkCommitted("8191 committed");
        checkScan("8191 scan", 4'b1111, SEG_TABLE[8], SEG_TABLE[1], SEG_TABLE[9], SEG_TABLE[1]);

        // Leading-zero blanking.
        display_ctrl = 2'b01;
        convert(42, busyCycles);
        check("42 busy cycles", 16'(busyCycles), 16'd14);
        checkCommitted("42 committed");
        checkScan("42 scan", 4'b0011, OFF, OFF, SEG_TABLE[4], SEG_TABLE[2]);

        // Back-to-back: 7 is overwritten by 55 while 100 converts.
        display_score = 13'd100;
        score_valid   = 1'b1;
        expQ.push_back(toBcd(100));
        busyRun  = 0;
        runOpen  = 1'b1;
        sawSeven = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            score_valid = 1'b0;
            if (runOpen) begin
                if (busy === 1'b1) busyRun++;
                else runOpen = 1'b0;
            end
            if (dut.converter.bcd === toBcd(7)) sawSeven = 1'b1;
            if (k == 15) checkCommitted("b2b first");
            if (k == 29) checkCommitted("b2b second");
            if (k == 3 || k == 8) begin
                display_score = (k == 3) ? 13'd7 : 13'd55;
                score_valid   = 1'b1;
                if (expQ.size() > 1) expQ[expQ.size() - 1] = toBcd(int'(display_score));
                else expQ.push_back(toBcd(int'(display_score)));
            end
        end
        check("b2b busy run", 16'(busyRun), 16'd28);
        check("b2b 7 never committed", 16'(sawSeven), 16'd0);

        // Mode sweep on 1234.
        display_ctrl = 2'b10;
        convert(1234, busyCycles);
        checkCommitted("1234 committed");
        checkScan("1234 full", 4'b1111, SEG_TABLE[1], SEG_TABLE[2], SEG_TABLE[3], SEG_TABLE[4]);
        display_ctrl = 2'b00;
        tick();
        tick();
        check("blank an", 16'(an), 16'hF);
        check("blank seg", 16'(seg), 16'(OFF));
        checkScan("blank scan", 4'b0000, OFF, OFF, OFF, OFF);
        display_ctrl = 2'b11;
        tick();
        tick();
        check("dash seg", 16'(seg), 16'(DASH));
        check("dash an lit", 16'(an != 4'b1111), 16'd1);
        checkScan("dash scan", 4'b1111, DASH, DASH, DASH, DASH);

        // Reset five cycles into a conversion of 999.
        display_ctrl  = 2'b01;
        display_score = 13'd999;
        score_valid   = 1'b1;
        tick();
        score_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("999 busy before reset", 16'(busy), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async busy clear", 16'(busy), 16'd0);
        check("async committed clear", dut.converter.bcd, 16'd0);
        check("async an off", 16'(an), 16'hF);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        convert(3, busyCycles);
        check("3 busy cycles", 16'(busyCycles), 16'd14);
        checkCommitted("3 committed");
        checkScan("3 scan", 4'b0001, OFF, OFF, OFF, SEG_TABLE[3]);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
